lsu_mc: RTL
===========

// Module: lsu_mc
// PURPOSE
//  Multi-cycle load/store unit: successor to the combinational memory unit of the single-cycle core.
//  Takes one load/store per request, drives a valid/ready data bus with variable latency, aligns
//  and sign-extends load data, and reports misaligned/access-fault/timeout exceptions to TRAP.
//  Sits between EXU (address = alu_result) and the data bus; the core stalls while busy.
// PARAMETERS
//  XLEN       32   data/address width (32 only; 64 reserved)
//  TIMEOUT    255  max cycles in REQ+WAIT before access fault; 0 = no timeout
//  MISALIGN_EN 1   1: misaligned access -> exception, no bus cycle; 0: address forced aligned
// PORTS
//  clk         in   1       clock
//  rst_b       in   1       synchronous reset, ACTIVE-HIGH (1 = reset), sampled on posedge clk
//  req_valid   in   1       request from core
//  req_ready   out  1       1 only in IDLE
//  req_write   in   1       1 = store, 0 = load
//  req_opcode  in   3       funct3: B=000 H=001 W=010 BU=100 HU=101 (stores use 000/001/010)
//  req_addr    in   XLEN    byte address
//  req_wdata   in   XLEN    rs2 data (store)
//  rsp_valid   out  1       one-cycle completion pulse
//  rsp_rdata   out  XLEN    aligned/extended load data (0 for stores and errors)
//  rsp_err     out  1       exception on this completion
//  rsp_cause   out  4       4 ld-misalign, 5 ld-fault, 6 st-misalign, 7 st-fault
//  bus_valid   out  1       bus request
//  bus_ready   in   1       bus accepts request
//  bus_wen     out  1       write
//  bus_addr    out  XLEN    word-aligned address ({addr[XLEN-1:2],2'b0})
//  bus_wstrb   out  4       byte strobes
//  bus_wdata   out  XLEN    lane-replicated store data
//  bus_rvalid  in   1       response (read data or write ack)
//  bus_rdata   in   XLEN    read word
//  bus_err     in   1       response error, valid with bus_rvalid
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0 except req_ready=1; timeout counter 0.
//  FSM states IDLE, REQ, WAIT, RESP.
//  IDLE: req_valid&req_ready -> capture write/opcode/addr/wdata.
//    misaligned (H: addr[0]!=0, W: addr[1:0]!=0) & MISALIGN_EN -> RESP, err=1, cause 4/6.
//    else -> REQ.
//  REQ: bus_valid=1, bus_* stable until bus_ready. bus_ready & bus_rvalid same cycle -> RESP;
//    bus_ready alone -> WAIT.
//  WAIT: bus_rvalid -> RESP; err=bus_err (cause 5/7), rdata captured.
//  RESP: rsp_valid=1 for exactly one cycle -> IDLE. Core must consume; no rsp backpressure.
//  Timeout: counter clears on IDLE->REQ, increments each REQ/WAIT cycle; reaching TIMEOUT -> RESP,
//    err=1, cause 5/7, bus_valid drops. bus_rvalid outside WAIT (late) ignored.
//  Min latency (aligned, zero-wait bus): accept cycle 0, REQ 1, RESP 2 -> 3 cycles incl. accept.
//  Store: B wdata={4{wdata[7:0]}}, wstrb=4'b0001<<addr[1:0]; H wdata={2{wdata[15:0]}},
//    wstrb=4'b0011<<addr[1:0]; W wdata as is, 4'b1111. Loads: wstrb=0.
//  Load: shift bus_rdata right by 8*addr[1:0]; B/H sign-extend, BU/HU zero-extend, W raw.
//  Invalid opcode (011,11x; or 1xx on store): treated as W (documented don't-care for IDU).
//  Reset in any state: next edge -> IDLE, bus_valid=0, no rsp_valid; bus slave must drop request.
// STRUCTURE
//  lsu_pkg: memop_e (funct3 enum), lsu_state_e, cause constants (LD/ST_MISALIGN, LD/ST_FAULT).
//  lsu_align: combinational sub-module (strobe/replicate for stores, shift/extend for loads),
//    shared with future cached LSU. lsu_mc holds FSM, capture regs, timeout counter.
// TESTING
//  LW addr 0x8000_0004, bus_ready+rvalid same cycle, rdata 0xDEAD_BEEF -> rsp 3 cycles, 0xDEADBEEF.
//  LB addr ..._0003, rdata 0x80xx_xxxx -> 0xFFFF_FF80; LBU -> 0x0000_0080; LHU @2 0xF00Dxxxx -> 0xF00D.
//  SH addr ..._0002, wdata 0x1234_ABCD -> bus_wdata 0xABCD_ABCD, wstrb 4'b1100, bus_addr ..._0000.
//  LW addr ..._0002 -> no bus_valid, rsp_err=1 cause 4; SH addr ..._0001 -> cause 6.
//  bus_ready held 0 with TIMEOUT=8 -> rsp_err cause 5 after 8 REQ cycles; late rvalid ignored.
//  rst_b=1 while in WAIT -> IDLE next cycle, no rsp_valid; next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: memory-op encoding,
// FSM states and exception cause codes.
package lsu_pkg;

  typedef enum logic [2:0] {
    MOP_B  = 3'b000,
    MOP_H  = 3'b001,
    MOP_W  = 3'b010,
    MOP_BU = 3'b100,
    MOP_HU = 3'b101
  } memop_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } lsu_state_e;

  localparam logic [3:0] LD_MISALIGN = 4'd4;
  localparam logic [3:0] LD_FAULT    = 4'd5;
  localparam logic [3:0] ST_MISALIGN = 4'd6;
  localparam logic [3:0] ST_FAULT    = 4'd7;

  // Unsupported funct3 codes collapse to a word access
  function automatic memop_e norm_op(
    input logic       wr,
    input logic [2:0] f3
  );
    memop_e op;
    op = MOP_W;
    if (wr) begin
      if (f3 == 3'b000) op = MOP_B;
      else if (f3 == 3'b001) op = MOP_H;
    end else begin
      unique case (f3)
        3'b000:  op = MOP_B;
        3'b001:  op = MOP_H;
        3'b100:  op = MOP_BU;
        3'b101:  op = MOP_HU;
        default: op = MOP_W;
      endcase
    end
    return op;
  endfunction

  function automatic logic misaligned(
    input memop_e     op,
    input logic [1:0] lo
  );
    logic m;
    m = 1'b0;
    if (op == MOP_H || op == MOP_HU) m = lo[0];
    else if (op == MOP_W) m = |lo;
    return m;
  endfunction

  function automatic logic [1:0] force_align(
    input memop_e     op,
    input logic [1:0] lo
  );
    logic [1:0] r;
    r = lo;
    if (op == MOP_H || op == MOP_HU) r = {lo[1], 1'b0};
    else if (op == MOP_W) r = 2'b00;
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: store strobes/replication and load
// shift plus sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            wr_i,
  input  logic [2:0]      op_i,
  input  logic [1:0]      lo_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      wstrb_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  memop_e          op;
  logic            is_b;
  logic            is_h;
  logic            uns;
  logic [XLEN-1:0] sh;

  always_comb begin
    op   = memop_e'(op_i);
    is_b = (op == MOP_B) || (op == MOP_BU);
    is_h = (op == MOP_H) || (op == MOP_HU);
    uns  = (op == MOP_BU) || (op == MOP_HU);
    sh   = rdata_i >> {lo_i, 3'b000};
    wstrb_o = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = sh;
    unique case (1'b1)
      is_b: begin
        wstrb_o = 4'b0001 << lo_i;
        wdata_o = {(XLEN/8){wdata_i[7:0]}};
        rdata_o = {{(XLEN-8){sh[7] & ~uns}}, sh[7:0]};
      end
      is_h: begin
        wstrb_o = 4'b0011 << lo_i;
        wdata_o = {(XLEN/16){wdata_i[15:0]}};
        rdata_o = {{(XLEN-16){sh[15] & ~uns}}, sh[15:0]};
      end
      default: begin
        rdata_o = rdata_i;
      end
    endcase
    if (!wr_i) wstrb_o = 4'b0000;
  end

endmodule

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: one request at a time over a
// valid/ready data bus, with misalign, fault and timeout traps.
module lsu_mc
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT     = 255,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_opcode,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [3:0]      rsp_cause,
  output logic            bus_valid,
  input  logic            bus_ready,
  output logic            bus_wen,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_wstrb,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  lsu_state_e      state_q, state_d;
  logic            wr_q, wr_d;
  memop_e          op_q, op_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [3:0]      cause_q, cause_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [3:0]      strb;
  logic [XLEN-1:0] wrep;
  logic [XLEN-1:0] rext;
  memop_e          op_n;
  logic            done;
  logic            fault;
  logic            to_hit;

  lsu_align #(.XLEN(XLEN)) u_align (
    .wr_i    (wr_q),
    .op_i    (op_q),
    .lo_i    (addr_q[1:0]),
    .wdata_i (wdata_q),
    .rdata_i (bus_rdata),
    .wstrb_o (strb),
    .wdata_o (wrep),
    .rdata_o (rext)
  );

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    rsp_cause = 4'd0;
    bus_valid = 1'b0;
    bus_wen   = 1'b0;
    bus_addr  = '0;
    bus_wstrb = 4'b0000;
    bus_wdata = '0;
    done      = 1'b0;
    fault     = 1'b0;
    op_n      = norm_op(req_write, req_opcode);
    to_hit    = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wr_d    = req_write;
          op_d    = op_n;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          cause_d = 4'd0;
          cnt_d   = '0;
          if (MISALIGN_EN) begin
            addr_d = req_addr;
          end else begin
            addr_d = {req_addr[XLEN-1:2],
                      force_align(op_n, req_addr[1:0])};
          end
          if (MISALIGN_EN && misaligned(op_n, req_addr[1:0])) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            cause_d = req_write ? ST_MISALIGN : LD_MISALIGN;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        bus_valid = 1'b1;
        bus_wen   = wr_q;
        bus_addr  = {addr_q[XLEN-1:2], 2'b00};
        bus_wstrb = strb;
        bus_wdata = wrep;
        cnt_d     = cnt_q + CW'(1);
        if (bus_ready && bus_rvalid) done = 1'b1;
        else if (to_hit) fault = 1'b1;
        else if (bus_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_rvalid) done = 1'b1;
        else if (to_hit) fault = 1'b1;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        rsp_cause = cause_q;
        state_d   = S_IDLE;
      end
    endcase

    // A bus error on the response yields no load data
    if (done) begin
      state_d = S_RESP;
      err_d   = bus_err;
      cause_d = bus_err ? (wr_q ? ST_FAULT : LD_FAULT) : 4'd0;
      rdata_d = (wr_q || bus_err) ? '0 : rext;
    end
    if (fault) begin
      state_d = S_RESP;
      err_d   = 1'b1;
      cause_d = wr_q ? ST_FAULT : LD_FAULT;
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      op_q    <= MOP_B;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cause_q <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
